// File: rtl/sent_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : sent_tx_frame
// Description : SENT transmit frame sequencer. Accepts a status nibble plus
//               six data nibbles, drives an external CRC4 block over the data
//               nibbles, latches the returned CRC and serialises
//               sync / status / data0..5 / CRC / optional pause as tick-timed
//               pulses on the SENT line.
// Ports       : clk, reset         - clock, async active-high reset
//               frame_valid/ready  - frame request handshake (ready in IDLE)
//               status_nib         - status nibble, captured at accept
//               data_nibs          - D0=[23:20] .. D5=[3:0], captured at accept
//               pause_en/ticks     - optional pause symbol, clamped to >=12
//               crc_clr/en/din     - drive to CRC4 block
//               crc_value          - CRC4 result
//               sent_out           - SENT line, idle high
//               busy, frame_done   - frame in progress / completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module sent_tx_frame #(
  parameter int TICK_DIV   = 8,
  parameter int LOW_TICKS  = 5,
  parameter int SYNC_TICKS = 56,
  parameter int NIB_BASE   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [3:0]  status_nib,
  input  logic [23:0] data_nibs,
  input  logic        pause_en,
  input  logic [9:0]  pause_ticks,
  output logic        crc_clr,
  output logic        crc_en,
  output logic [3:0]  crc_din,
  input  logic [3:0]  crc_value,
  output logic        sent_out,
  output logic        busy,
  output logic        frame_done
);

  localparam int              c_TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_TW-1:0] c_TICK_LAST  = c_TW'(TICK_DIV - 1);
  localparam logic [9:0]      c_SYNC_LEN   = 10'(SYNC_TICKS);
  localparam logic [9:0]      c_NIB_BASE   = 10'(NIB_BASE);
  localparam logic [9:0]      c_LOW_LEN    = 10'(LOW_TICKS);
  localparam logic [9:0]      c_PAUSE_MIN  = 10'd12;

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_SYNC   = 3'd1;
  localparam logic [2:0] c_S_STATUS = 3'd2;
  localparam logic [2:0] c_S_DATA   = 3'd3;
  localparam logic [2:0] c_S_CRC    = 3'd4;
  localparam logic [2:0] c_S_PAUSE  = 3'd5;

  logic [2:0]      r_state, w_next;
  logic [c_TW-1:0] r_tick;
  logic [9:0]      r_sym;        // tick index within the current symbol
  logic [2:0]      r_idx;        // data nibble index during DATA
  logic [3:0]      r_cyc;        // clk cycles since sync start, saturating
  logic [3:0]      r_status;
  logic [23:0]     r_data;
  logic            r_pause_en;
  logic [9:0]      r_pause_len;
  logic [3:0]      r_crc;
  logic            r_crc_clr, r_crc_en, r_frame_done;
  logic [3:0]      r_crc_din;

  logic            w_ready, w_accept, w_tick, w_sym_last, w_feed;
  logic [9:0]      w_total;

  function automatic logic [3:0] f_nib(input logic [23:0] d, input logic [2:0] i);
    case (i)
      3'd0:    f_nib = d[23:20];
      3'd1:    f_nib = d[19:16];
      3'd2:    f_nib = d[15:12];
      3'd3:    f_nib = d[11:8];
      3'd4:    f_nib = d[7:4];
      3'd5:    f_nib = d[3:0];
      default: f_nib = 4'h0;
    endcase
  endfunction

  assign w_tick     = (r_tick == c_TICK_LAST);
  assign w_sym_last = w_tick && (r_sym == (w_total - 10'd1));
  // CRC feed window: sync-start offsets 0..5 drive crc_en on the next cycle
  assign w_feed     = (r_state != c_S_IDLE) && (r_cyc < 4'd6);

  // Total length of the symbol currently being sent, in ticks
  always_comb begin
    w_total = 10'd0;
    case (r_state)
      c_S_SYNC:   w_total = c_SYNC_LEN;
      c_S_STATUS: w_total = c_NIB_BASE + {6'd0, r_status};
      c_S_DATA:   w_total = c_NIB_BASE + {6'd0, f_nib(r_data, r_idx)};
      c_S_CRC:    w_total = c_NIB_BASE + {6'd0, r_crc};
      c_S_PAUSE:  w_total = r_pause_len;
      default:    w_total = 10'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE:   if (w_accept)   w_next = c_S_SYNC;
      c_S_SYNC:   if (w_sym_last) w_next = c_S_STATUS;
      c_S_STATUS: if (w_sym_last) w_next = c_S_DATA;
      c_S_DATA:   if (w_sym_last && (r_idx == 3'd5)) w_next = c_S_CRC;
      c_S_CRC:    if (w_sym_last) w_next = r_pause_en ? c_S_PAUSE : c_S_IDLE;
      c_S_PAUSE:  if (w_sym_last) w_next = c_S_IDLE;
      default:    w_next = c_S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    // frame_ready is held off during the frame_done cycle
    w_ready  = (r_state == c_S_IDLE) && !r_frame_done;
    w_accept = frame_valid && w_ready;
    sent_out = (r_state == c_S_IDLE) || (r_sym >= c_LOW_LEN);
    busy     = (r_state != c_S_IDLE) || w_accept;
  end

  assign frame_ready = w_ready;
  assign crc_clr     = r_crc_clr;
  assign crc_en      = r_crc_en;
  assign crc_din     = r_crc_din;
  assign frame_done  = r_frame_done;

  // Datapath: capture, tick/symbol counters, CRC sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick       <= '0;
      r_sym        <= 10'd0;
      r_idx        <= 3'd0;
      r_cyc        <= 4'd0;
      r_status     <= 4'd0;
      r_data       <= 24'd0;
      r_pause_en   <= 1'b0;
      r_pause_len  <= 10'd0;
      r_crc        <= 4'd0;
      r_crc_clr    <= 1'b0;
      r_crc_en     <= 1'b0;
      r_crc_din    <= 4'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_crc_clr    <= w_accept;
      r_crc_en     <= w_feed;
      r_crc_din    <= w_feed ? f_nib(r_data, r_cyc[2:0]) : 4'd0;
      r_frame_done <= (r_state != c_S_IDLE) && (w_next == c_S_IDLE);
      if (w_accept) begin
        r_status    <= status_nib;
        r_data      <= data_nibs;
        r_pause_en  <= pause_en;
        r_pause_len <= (pause_ticks < c_PAUSE_MIN) ? c_PAUSE_MIN : pause_ticks;
        r_tick      <= '0;
        r_sym       <= 10'd0;
        r_idx       <= 3'd0;
        r_cyc       <= 4'd0;
      end else if (r_state != c_S_IDLE) begin
        r_tick <= w_tick ? '0 : r_tick + 1'b1;
        if (w_tick) r_sym <= w_sym_last ? 10'd0 : r_sym + 10'd1;
        if (w_sym_last && (r_state == c_S_DATA)) r_idx <= r_idx + 3'd1;
        if (r_cyc != 4'hF) r_cyc <= r_cyc + 4'd1;
        // CRC block has absorbed D5 by now; latch before the sync pulse ends
        if (r_cyc == 4'd7) r_crc <= crc_value;
      end
    end
  end

endmodule
`default_nettype wire
